// File: rtl/rs_pipeline_sequencer.sv
// Reed-Solomon decode pipeline sequencer: tracks stage occupancy,
// pulses stage starts, gathers dones, and issues a global advance.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   enable              0 freezes accept/advance and the wait counter
//   flush               discards all in-flight blocks (err is kept)
//   block_valid/ready   host block handshake (ready pulses in ADV)
//   stage_done          per-stage completion (pulse or level)
//   stage_start         one-cycle start pulse to each occupied stage
//   advance             one-cycle pulse shifting all stage buffers
//   occupancy           stage i holds a valid block
//   out_valid/out_ack   decoded-buffer handshake with the host
//   err/err_clear       sticky wait timeout and its clear
//   irq                 pulse on out_valid or err rising
module rs_pipeline_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  block_valid,
  output logic                  block_ready,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic                  advance,
  output logic [NUM_STAGES-1:0] occupancy,
  output logic                  out_valid,
  input  logic                  out_ack,
  output logic                  err,
  input  logic                  err_clear,
  output logic                  irq
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ADV,
    S_START
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_STAGES-1:0] occ_q, occ_d;
  logic [NUM_STAGES-1:0] done_q, done_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ov_q, ov_d;
  logic                  err_q, err_d;
  logic                  irq_q, irq_d;

  logic                  fire_adv;
  logic                  fire_start;
  logic [NUM_STAGES-1:0] done_acc;
  logic                  done_all;
  logic                  stall;
  logic                  go;
  logic                  expire;

  // Flush and freeze suppress the pulses of the ADV/START states.
  assign fire_adv   = (state_q == S_ADV) & enable & ~flush;
  assign fire_start = (state_q == S_START) & enable & ~flush;

  assign done_acc = done_q | stage_done;
  assign done_all = &(done_acc | ~occ_q);
  assign stall    = ov_q & occ_q[NUM_STAGES-1] & ~out_ack;
  assign go       = enable & done_all & ~stall;

  always_comb begin
    state_d = state_q;
    occ_d   = occ_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    err_d   = err_q;
    expire  = 1'b0;

    if (err_clear) err_d = 1'b0;
    if (out_ack)   ov_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enable & block_valid) state_d = S_ADV;
      end
      S_WAIT: begin
        done_d = done_acc;
        if (go) begin
          state_d = S_ADV;
          // The coming advance refills the decoded buffer,
          // so keep out_valid high across the ack.
          if (occ_q[NUM_STAGES-1]) ov_d = ov_q;
        end else if (enable) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_PRE) expire = 1'b1;
        end
      end
      S_ADV: begin
        if (enable) begin
          if (occ_q[NUM_STAGES-1]) ov_d = 1'b1;
          occ_d   = {occ_q[NUM_STAGES-2:0], block_valid};
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (enable) begin
          done_d  = '0;
          state_d = (occ_q == '0) ? S_IDLE : S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (expire) err_d = 1'b1;

    if (flush) begin
      state_d = S_IDLE;
      occ_d   = '0;
      ov_d    = 1'b0;
      done_d  = '0;
      cnt_d   = '0;
    end

    irq_d = (ov_d & ~ov_q) | (err_d & ~err_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      occ_q   <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
    end
  end

  assign advance     = fire_adv;
  assign block_ready = fire_adv;
  assign stage_start = fire_start ? occ_q : '0;
  assign occupancy   = occ_q;
  assign out_valid   = ov_q;
  assign err         = err_q;
  assign irq         = irq_q;

endmodule
